// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Brief    : E-stage multiply/divide unit. Holds the architectural HI/LO
//            registers, computes MULT/MULTU/DIV/DIVU results into shadow
//            registers at issue, then exposes them after a fixed busy window.
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_LAT);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DIV_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_sh_hi;
    logic [31:0]        r_sh_lo;

    logic               w_long_op;
    logic               w_is_mul;
    logic               w_done;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_q_s;
    logic [31:0]        w_r_s;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign w_is_mul  = (op == c_OP_MULT) || (op == c_OP_MULTU);
    assign w_long_op = w_is_mul || (op == c_OP_DIV) || (op == c_OP_DIVU);
    assign w_done    = (r_state == c_ST_BUSY) && (r_cnt == c_CNT_ONE);

    // Both operands widened to 64 bits so the truncated product is exact.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow case,
    // whose magnitude quotient 2^31 reads back as 0x80000000 with sign fixed.
    assign w_a_mag = A[31] ? (32'd0 - A) : A;
    assign w_b_mag = B[31] ? (32'd0 - B) : B;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_q_s   = (A[31] ^ B[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s   = A[31] ? (32'd0 - w_r_mag) : w_r_mag;

    // Result selection; divide-by-zero re-captures current HI/LO so completion is a no-op.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (op)
            c_OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            c_OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            c_OP_DIV: begin
                if (B != 32'd0) begin
                    w_res_hi = w_r_s;
                    w_res_lo = w_q_s;
                end
            end
            c_OP_DIVU: begin
                if (B != 32'd0) begin
                    w_res_hi = A % B;
                    w_res_lo = A / B;
                end
            end
            default: begin
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: enter BUSY on an accepted long op, leave on the last count.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start && w_long_op) begin
                    w_next_state = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Output decode of the state machine.
    always_comb begin
        busy = (r_state == c_ST_BUSY);
    end

    // Datapath: issue/capture, countdown, commit, and direct MTHI/MTLO writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_sh_hi <= 32'd0;
            r_sh_lo <= 32'd0;
        end else if (r_state == c_ST_BUSY) begin
            // Any start seen here is dropped; the in-flight op owns the unit.
            r_cnt <= r_cnt - c_CNT_ONE;
            if (w_done) begin
                r_hi <= r_sh_hi;
                r_lo <= r_sh_lo;
            end
        end else if (start) begin
            if (w_long_op) begin
                r_sh_hi <= w_res_hi;
                r_sh_lo <= w_res_lo;
                r_cnt   <= w_is_mul ? c_MUL_CNT : c_DIV_CNT;
            end else if (op == c_OP_MTHI) begin
                r_hi <= A;
            end else if (op == c_OP_MTLO) begin
                r_lo <= A;
            end
        end
    end

    assign HI      = r_hi;
    assign LO      = r_lo;
    assign MDU_out = rd_sel ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu
// Brief    : Directed, table-driven self-checking bench for e_mdu, plus
//            hand sequences for start-while-busy and reset-abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_out;

    int checks;
    int errors;

    e_mdu #(
        .MUL_LAT(5),
        .DIV_LAT(10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .rd_sel (rd_sel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDU_out(MDU_out)
    );

    // 10-time-unit clock; inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait is ever unbounded.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          cyc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive one issue cycle, return at the next falling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Count falling edges with busy high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] eh, input logic [31:0] el);
        check({tag, " HI"}, HI, eh);
        check({tag, " LO"}, LO, el);
        rd_sel = 1'b0;
        #1;
        check({tag, " MDU_out(LO)"}, MDU_out, el);
        rd_sel = 1'b1;
        #1;
        check({tag, " MDU_out(HI)"}, MDU_out, eh);
        rd_sel = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;

        //                op     A             B             preHI         preLO         cyc  expHI         expLO
        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000000, 32'h00000000, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000001, 32'h00000001, 5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000000, 32'h00000000, 10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000005, 32'h00000006, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 10, 32'h00000011, 32'h00000022};
        vecs[6]  = '{3'd4, 32'hFFFFFFFF, 32'h00000000, 32'h000000AA, 32'h000000BB, 10, 32'h000000AA, 32'h000000BB};
        vecs[7]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 5,  32'h40000000, 32'h00000000};
        vecs[8]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[9]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000000, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 10, 32'h80000000, 32'h00000000};
        vecs[11] = '{3'd6, 32'hDEADBEEF, 32'h00000000, 32'h00000003, 32'h00000004, 0,  32'h00000003, 32'hDEADBEEF};
        vecs[12] = '{3'd5, 32'h00001234, 32'h00000000, 32'h00000003, 32'h00000004, 0,  32'h00001234, 32'h00000004};
        vecs[13] = '{3'd0, 32'h00000099, 32'h00000099, 32'h00000007, 32'h00000008, 0,  32'h00000007, 32'h00000008};
        vecs[14] = '{3'd7, 32'h00000099, 32'h00000099, 32'h00000007, 32'h00000008, 0,  32'h00000007, 32'h00000008};
        vecs[15] = '{3'd3, 32'hFFFFFF9C, 32'h00000007, 32'h00000000, 32'h00000000, 10, 32'hFFFFFFFE, 32'hFFFFFFF2};

        // Reset with a start pending: it must be ignored.
        reset  = 1'b0;
        start  = 1'b1;
        op     = 3'd5;
        A      = 32'h0000FFFF;
        B      = 32'd0;
        rd_sel = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check_outputs("reset", 32'd0, 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            issue(3'd5, vecs[i].pre_hi, 32'd0);
            issue(3'd6, vecs[i].pre_lo, 32'd0);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            if (vecs[i].cyc > 0) begin
                check($sformatf("v%0d HI held while busy", i), HI, vecs[i].pre_hi);
                check($sformatf("v%0d LO held while busy", i), LO, vecs[i].pre_lo);
            end
            wait_idle(n);
            check($sformatf("v%0d busy cycles", i), n, vecs[i].cyc);
            check_outputs($sformatf("v%0d", i), vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Start of MTHI during a MULT busy window must be dropped.
        issue(3'd5, 32'h00000077, 32'd0);
        issue(3'd6, 32'h00000088, 32'd0);
        issue(3'd1, 32'd5, 32'd3);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 2) begin
                start = 1'b1;
                op    = 3'd5;
                A     = 32'h00001234;
            end else begin
                start = 1'b0;
                op    = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        op    = 3'd0;
        check("mthi-in-busy busy cycles", n, 32'd5);
        check_outputs("mthi-in-busy", 32'd0, 32'd15);

        // Reset on cycle 3 of a DIV aborts it; a MULT may issue right after.
        issue(3'd5, 32'h00000055, 32'd0);
        issue(3'd6, 32'h00000066, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        check("abort MDU_out", MDU_out, 32'd0);
        issue(3'd1, 32'd6, 32'd7);
        wait_idle(n);
        check("post-abort mult busy cycles", n, 32'd5);
        check_outputs("post-abort mult", 32'd0, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
